// File: rtl/lcd_hd44780_tx.sv
// rtl/lcd_hd44780_tx.sv - write-only HD44780 character-LCD transmitter with timed EN strobe
module lcd_hd44780_tx #(
    parameter int SETUP_CYC    = 2,
    parameter int EN_HIGH_CYC  = 12,
    parameter int HOLD_CYC     = 2,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic [7:0] o_lcd_data
);

    localparam int CW = $clog2(CLR_WAIT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_load;
    logic            cnt_reload;
    logic            cnt_done;
    logic            long_wait;
    logic            accept;
    logic            en_nxt;

    assign cnt_done = (cnt == CW'(1));
    assign accept   = (state == S_IDLE) && i_valid;
    assign o_lcd_rw = 1'b0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Each state's length is loaded on entry and the state ends when the count reaches 1.
    always_comb begin
        state_nxt  = state;
        cnt_load   = '0;
        cnt_reload = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_valid) begin
                    state_nxt  = S_SETUP;
                    cnt_load   = CW'(SETUP_CYC);
                    cnt_reload = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_done) begin
                    state_nxt  = S_PULSE;
                    cnt_load   = CW'(EN_HIGH_CYC);
                    cnt_reload = 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt_done) begin
                    state_nxt  = S_HOLD;
                    cnt_load   = CW'(HOLD_CYC);
                    cnt_reload = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_done) begin
                    state_nxt  = S_WAIT;
                    cnt_load   = long_wait ? CW'(CLR_WAIT_CYC) : CW'(CMD_WAIT_CYC);
                    cnt_reload = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_done) begin
                    state_nxt  = S_IDLE;
                    cnt_reload = 1'b1;
                end
            end
            default: begin
                state_nxt  = S_IDLE;
                cnt_reload = 1'b1;
            end
        endcase
    end

    // EN is registered from the next state so the pin never sees a combinational path.
    always_comb begin
        o_ready = (state == S_IDLE);
        o_busy  = (state != S_IDLE);
        en_nxt  = (state_nxt == S_PULSE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt        <= '0;
            o_lcd_en   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= 8'h00;
            long_wait  <= 1'b0;
        end else begin
            o_lcd_en <= en_nxt;
            if (cnt_reload) begin
                cnt <= cnt_load;
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (accept) begin
                o_lcd_rs   <= i_rs;
                o_lcd_data <= i_data;
                // Clear display / return home need the long execution wait.
                long_wait  <= !i_rs && (i_data[7:2] == 6'b0) && (i_data[1:0] != 2'b00);
            end
        end
    end

endmodule
